gat_load_ctrl: RTL and testbench
================================

GAT_LOAD_CTRL -- requirements
Module: gat_load_ctrl

Interface
REQ-001 Parameters SHALL be: TOP_WIDTH=32 (stream/BRAM word bits); SUBGRAPH_IDX_DEPTH=13264, H_DATA_DEPTH=242101, NODE_INFO_DEPTH=13264, WEIGHT_DEPTH=22928, NEW_FEATURE_DEPTH=43328 (words per region); TIMEOUT_CYCLES=2**24.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high. Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load/run/readout sequence
- s_data  in  TOP_WIDTH  input word stream
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when high with s_valid
- bram_din  out  TOP_WIDTH  shared write data to all load BRAMs
- bram_addra  out  AW+2  byte address (word index <<2), AW = clog2 of largest load depth
- subgraph_bram_ena / _wea, h_data_bram_ena / _wea, h_node_info_bram_ena / _wea, wgt_bram_ena / _wea  out  1 each  per-region write strobes
- h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done  out  1 each  level load-complete flags
- gat_ready  in  1  accelerator finished (level)
- feat_bram_addrb  out  clog2(NEW_FEATURE_DEPTH)+2  feature read byte address
- feat_bram_dout  in  TOP_WIDTH  feature data, valid 1 cycle after address
- m_data  out  TOP_WIDTH  output feature word; m_valid  out  1; m_ready  in  1; m_last  out  1  final word
- busy  out  1  high in every state except IDLE; err  out  1  timeout flag

Function
REQ-003 FSM states SHALL be IDLE, LD_SUBG, LD_H, LD_INFO, LD_WGT, WAIT_GAT, RD_ADDR, RD_DATA, RD_OUT, ERR.
REQ-004 In IDLE, start SHALL move to LD_SUBG and clear all load_done flags, err and the word counter; start in any other state SHALL be ignored.
REQ-005 s_ready SHALL be high only in LD_* states; each accepted word SHALL produce, one cycle later, bram_din=s_data, bram_addra=count<<2, and ena=wea=1 on the active region only (all strobes low otherwise).
REQ-006 When the word with count = DEPTH-1 of a region is accepted, the counter SHALL wrap to 0 and the FSM SHALL advance LD_SUBG->LD_H->LD_INFO->LD_WGT->WAIT_GAT.
REQ-007 The matching load_done flag SHALL rise in the same cycle as the final write strobe of its region and stay high until the next accepted start; LD_SUBG has no flag.
REQ-008 In WAIT_GAT, gat_ready=1 SHALL move to RD_ADDR with the read index at 0.
REQ-009 The readout SHALL work as follows: RD_ADDR drives feat_bram_addrb=idx<<2; RD_DATA captures feat_bram_dout into m_data; RD_OUT holds m_valid=1 until m_ready, then increments idx and returns to RD_ADDR, or goes to IDLE after idx = NEW_FEATURE_DEPTH-1. Throughput is one word per 3 cycles at most.
REQ-010 m_last SHALL be high with m_valid only for idx = NEW_FEATURE_DEPTH-1; m_data SHALL be stable while m_valid=1 and m_ready=0.
REQ-011 s_valid stalls SHALL insert bubbles only: no strobe, no count change.

Reset
REQ-012 Asserting rst SHALL immediately force state IDLE, counters 0, and every output 0 (s_ready, strobes, load_done flags, m_valid, m_last, busy, err, addresses, data), including mid-load and mid-readout.

Configuration
REQ-013 Macro GAT_LOAD_TIMEOUT_EN: when defined, a WAIT_GAT cycle counter SHALL move the FSM to ERR with err=1 after TIMEOUT_CYCLES cycles without gat_ready. ERR holds until start, which restarts at LD_SUBG. When undefined, no counter or ERR entry exists and err is tied 0.

Structure
REQ-014 A shared package gat_pkg SHALL hold the FSM state enum and region-select typedef; depth defaults come from the existing dataset defines.
REQ-015 The feature readout (RD_* states, m_* handshake) SHALL be a sub-module gat_feat_reader started by a pulse and returning a done pulse.

Verification
REQ-016 Depths 2/4/3/5, feature depth 3; start, 14 back-to-back words 0..13 -> subgraph strobes at byte addresses 0,4 with data 0,1; h_data 0..12 with data 2..5; wgt last write data 13 at address 16, wgt_bram_load_done rising in that cycle.
REQ-017 Same load with s_valid toggled every other cycle -> identical write sequence; no strobe in idle cycles.
REQ-018 gat_ready=1, feat_bram_dout = 0xA0+index, m_ready low for 4 cycles on word 1 -> m_data 0xA0, 0xA1 (held), 0xA2 with m_last on 0xA2; then IDLE and busy=0.
REQ-019 rst pulse during LD_H after 2 words -> all outputs 0 at once; new start reloads from subgraph address 0.
REQ-020 With GAT_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=8, gat_ready held 0 -> err=1 after 8 WAIT_GAT cycles; start -> err=0, LD_SUBG entered.

Source files
------------

// File: rtl/gat_pkg.sv
// -----------------------------------------------------------------------------
// gat_pkg
// Shared definitions for the GAT load controller slice:
//   - dataset region depths (overridable through the DS_* dataset defines)
//   - FSM state enum used by the controller and the feature reader
//   - write-region select enum for the shared BRAM write port
//   - helper to size the shared load address bus
// Configuration macro: GAT_LOAD_TIMEOUT_EN (adds the WAIT_GAT timeout default)
// -----------------------------------------------------------------------------
`ifndef DS_SUBGRAPH_IDX_DEPTH
`define DS_SUBGRAPH_IDX_DEPTH 13264
`endif
`ifndef DS_H_DATA_DEPTH
`define DS_H_DATA_DEPTH 242101
`endif
`ifndef DS_NODE_INFO_DEPTH
`define DS_NODE_INFO_DEPTH 13264
`endif
`ifndef DS_WEIGHT_DEPTH
`define DS_WEIGHT_DEPTH 22928
`endif
`ifndef DS_NEW_FEATURE_DEPTH
`define DS_NEW_FEATURE_DEPTH 43328
`endif

package gat_pkg;

   localparam int SUBGRAPH_IDX_DEPTH_DEF = `DS_SUBGRAPH_IDX_DEPTH;
   localparam int H_DATA_DEPTH_DEF       = `DS_H_DATA_DEPTH;
   localparam int NODE_INFO_DEPTH_DEF    = `DS_NODE_INFO_DEPTH;
   localparam int WEIGHT_DEPTH_DEF       = `DS_WEIGHT_DEPTH;
   localparam int NEW_FEATURE_DEPTH_DEF  = `DS_NEW_FEATURE_DEPTH;
`ifdef GAT_LOAD_TIMEOUT_EN
   localparam int TIMEOUT_CYCLES_DEF     = 2**24;
`endif

   typedef enum logic [3:0] {
      IDLE,
      LD_SUBG,
      LD_H,
      LD_INFO,
      LD_WGT,
      WAIT_GAT,
      RD_ADDR,
      RD_DATA,
      RD_OUT,
      ERR
   } gat_state_e;

   typedef enum logic [2:0] {
      RGN_NONE,
      RGN_SUBG,
      RGN_H,
      RGN_INFO,
      RGN_WGT
   } gat_region_e;

   // The load regions share one address bus, so it is sized for the deepest one.
   function automatic int maxDepth(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/gat_feat_reader.sv
// -----------------------------------------------------------------------------
// gat_feat_reader
// Streams NEW_FEATURE_DEPTH words out of the feature BRAM onto a valid/ready
// output. One word takes at least three cycles: address, BRAM latency, output.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_start        one-cycle pulse, begins readout at index 0
//   o_done         one-cycle pulse when the final word is handed off
//   o_featAddr     feature BRAM byte address (index << 2)
//   i_featDout     feature BRAM data, valid one cycle after the address
//   o_mData        output word, held stable while stalled
//   o_mValid       output word valid
//   i_mReady       downstream ready
//   o_mLast        marks the final word
// -----------------------------------------------------------------------------
module gat_feat_reader
   import gat_pkg::*;
#(
   parameter int TOP_WIDTH = 32,
   parameter int DEPTH     = NEW_FEATURE_DEPTH_DEF,
   localparam int IW       = $clog2(DEPTH)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   output logic                 o_done,
   output logic [IW+1:0]        o_featAddr,
   input  logic [TOP_WIDTH-1:0] i_featDout,
   output logic [TOP_WIDTH-1:0] o_mData,
   output logic                 o_mValid,
   input  logic                 i_mReady,
   output logic                 o_mLast
);

   gat_state_e           r_state;
   gat_state_e           w_nextState;
   logic [IW-1:0]        r_idx;
   logic [TOP_WIDTH-1:0] r_mData;
   logic                 w_lastIdx;
   logic                 w_done;

   assign w_lastIdx = (r_idx == IW'(DEPTH - 1));

   // Walk address -> data -> output for each word; the handshake in RD_OUT
   // either loops back for the next index or finishes the whole readout.
   always_comb begin
      w_nextState = r_state;
      w_done      = 1'b0;
      case (r_state)
         IDLE:    if (i_start) w_nextState = RD_ADDR;
         RD_ADDR: w_nextState = RD_DATA;
         RD_DATA: w_nextState = RD_OUT;
         RD_OUT: begin
            if (i_mReady) begin
               if (w_lastIdx) begin
                  w_nextState = IDLE;
                  w_done      = 1'b1;
               end else begin
                  w_nextState = RD_ADDR;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   // Read index restarts at zero on every start and advances after each handoff.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
      end else if (r_state == IDLE && i_start) begin
         r_idx <= '0;
      end else if (r_state == RD_OUT && i_mReady && !w_lastIdx) begin
         r_idx <= r_idx + 1'b1;
      end
   end

   // Capture BRAM data once its read latency has elapsed; it then stays put
   // for as long as the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    r_mData <= '0;
      else if (r_state == RD_DATA) r_mData <= i_featDout;
   end

   assign o_featAddr = {r_idx, 2'b00};
   assign o_mData    = r_mData;
   assign o_mValid   = (r_state == RD_OUT);
   assign o_mLast    = (r_state == RD_OUT) && w_lastIdx;
   assign o_done     = w_done;

endmodule

// File: rtl/gat_load_ctrl.sv
// -----------------------------------------------------------------------------
// gat_load_ctrl
// Loads four BRAM regions (subgraph index, h data, node info, weights) from a
// single word stream, waits for the accelerator, then streams the new feature
// BRAM out through gat_feat_reader.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     pulse, begins load/run/readout (only from IDLE/ERR)
//   s_data/s_valid/s_ready    input word stream
//   bram_din, bram_addra      shared write data and byte address (one cycle after accept)
//   *_bram_ena/_wea           per-region write strobes
//   *_bram_load_done          level flags, set with the final write of a region
//   gat_ready                 accelerator finished
//   feat_bram_addrb/_dout     feature BRAM read port
//   m_data/m_valid/m_ready/m_last  output feature stream
//   busy                      high outside IDLE
//   err                       timeout flag
// Configuration macro: GAT_LOAD_TIMEOUT_EN enables the WAIT_GAT timeout to ERR;
// without it err is tied low.
// -----------------------------------------------------------------------------
module gat_load_ctrl
   import gat_pkg::*;
#(
   parameter int TOP_WIDTH          = 32,
   parameter int SUBGRAPH_IDX_DEPTH = SUBGRAPH_IDX_DEPTH_DEF,
   parameter int H_DATA_DEPTH       = H_DATA_DEPTH_DEF,
   parameter int NODE_INFO_DEPTH    = NODE_INFO_DEPTH_DEF,
   parameter int WEIGHT_DEPTH       = WEIGHT_DEPTH_DEF,
   parameter int NEW_FEATURE_DEPTH  = NEW_FEATURE_DEPTH_DEF,
`ifdef GAT_LOAD_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF,
`endif
   localparam int AW  = $clog2(maxDepth(SUBGRAPH_IDX_DEPTH, H_DATA_DEPTH,
                                        NODE_INFO_DEPTH, WEIGHT_DEPTH)),
   localparam int FAW = $clog2(NEW_FEATURE_DEPTH)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [TOP_WIDTH-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic [TOP_WIDTH-1:0] bram_din,
   output logic [AW+1:0]        bram_addra,
   output logic                 subgraph_bram_ena,
   output logic                 subgraph_bram_wea,
   output logic                 h_data_bram_ena,
   output logic                 h_data_bram_wea,
   output logic                 h_node_info_bram_ena,
   output logic                 h_node_info_bram_wea,
   output logic                 wgt_bram_ena,
   output logic                 wgt_bram_wea,
   output logic                 h_data_bram_load_done,
   output logic                 h_node_info_bram_load_done,
   output logic                 wgt_bram_load_done,
   input  logic                 gat_ready,
   output logic [FAW+1:0]       feat_bram_addrb,
   input  logic [TOP_WIDTH-1:0] feat_bram_dout,
   output logic [TOP_WIDTH-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic                 busy,
   output logic                 err
);

   gat_state_e           r_state;
   gat_state_e           w_nextState;
   gat_region_e          w_region;
   gat_region_e          r_wrRegion;
   logic [AW-1:0]        r_count;
   logic [AW-1:0]        w_depthM1;
   logic [TOP_WIDTH-1:0] r_bramDin;
   logic [AW+1:0]        r_bramAddr;
   logic                 r_hDone;
   logic                 r_infoDone;
   logic                 r_wgtDone;
   logic                 w_accept;
   logic                 w_lastWord;
   logic                 w_clearRun;
   logic                 w_rdStart;
   logic                 w_rdDone;

   // Map the load state to its region and last word index; outside the load
   // states there is no region, which also keeps s_ready low.
   always_comb begin
      w_region  = RGN_NONE;
      w_depthM1 = '0;
      case (r_state)
         LD_SUBG: begin w_region = RGN_SUBG; w_depthM1 = AW'(SUBGRAPH_IDX_DEPTH - 1); end
         LD_H:    begin w_region = RGN_H;    w_depthM1 = AW'(H_DATA_DEPTH - 1);       end
         LD_INFO: begin w_region = RGN_INFO; w_depthM1 = AW'(NODE_INFO_DEPTH - 1);    end
         LD_WGT:  begin w_region = RGN_WGT;  w_depthM1 = AW'(WEIGHT_DEPTH - 1);       end
         default: begin w_region = RGN_NONE; w_depthM1 = '0;                          end
      endcase
   end

   assign s_ready    = (w_region != RGN_NONE);
   assign w_accept   = s_valid && s_ready;
   assign w_lastWord = w_accept && (r_count == w_depthM1);

`ifdef GAT_LOAD_TIMEOUT_EN
   localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TOW-1:0] r_toCnt;
   logic           w_timeout;

   assign w_timeout = (r_toCnt == TOW'(TIMEOUT_CYCLES - 1));

   // Count consecutive WAIT_GAT cycles without gat_ready; any other state
   // re-arms the count so each run gets the full window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_toCnt <= '0;
      else if (r_state == WAIT_GAT && !gat_ready) r_toCnt <= r_toCnt + 1'b1;
      else                                    r_toCnt <= '0;
   end

   assign err = (r_state == ERR);
`else
   assign err = 1'b0;
`endif

   // Sequence the four load regions, hand the readout to the reader once the
   // accelerator reports done, and return to IDLE when the reader finishes.
   // The controller parks in RD_ADDR while the reader walks its RD_* states.
   always_comb begin
      w_nextState = r_state;
      w_clearRun  = 1'b0;
      w_rdStart   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = LD_SUBG;
               w_clearRun  = 1'b1;
            end
         end
         LD_SUBG: if (w_lastWord) w_nextState = LD_H;
         LD_H:    if (w_lastWord) w_nextState = LD_INFO;
         LD_INFO: if (w_lastWord) w_nextState = LD_WGT;
         LD_WGT:  if (w_lastWord) w_nextState = WAIT_GAT;
         WAIT_GAT: begin
            if (gat_ready) begin
               w_nextState = RD_ADDR;
               w_rdStart   = 1'b1;
            end
`ifdef GAT_LOAD_TIMEOUT_EN
            else if (w_timeout) begin
               w_nextState = ERR;
            end
`endif
         end
         RD_ADDR, RD_DATA, RD_OUT: if (w_rdDone) w_nextState = IDLE;
         ERR: begin
            if (start) begin
               w_nextState = LD_SUBG;
               w_clearRun  = 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   // Word counter within the current region; wraps when a region completes so
   // the next region starts writing at address zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (w_clearRun) begin
         r_count <= '0;
      end else if (w_accept) begin
         r_count <= w_lastWord ? '0 : r_count + 1'b1;
      end
   end

   // Register the write one cycle after acceptance. Stalled cycles load
   // RGN_NONE so no strobe fires, while data and address simply hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrRegion <= RGN_NONE;
         r_bramDin  <= '0;
         r_bramAddr <= '0;
      end else begin
         r_wrRegion <= w_accept ? w_region : RGN_NONE;
         if (w_accept) begin
            r_bramDin  <= s_data;
            r_bramAddr <= {r_count, 2'b00};
         end
      end
   end

   // Load-done flags are set on the same edge that registers the region's
   // final write, so they rise together with its last strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hDone    <= 1'b0;
         r_infoDone <= 1'b0;
         r_wgtDone  <= 1'b0;
      end else if (w_clearRun) begin
         r_hDone    <= 1'b0;
         r_infoDone <= 1'b0;
         r_wgtDone  <= 1'b0;
      end else if (w_lastWord) begin
         if (r_state == LD_H)    r_hDone    <= 1'b1;
         if (r_state == LD_INFO) r_infoDone <= 1'b1;
         if (r_state == LD_WGT)  r_wgtDone  <= 1'b1;
      end
   end

   assign bram_din                   = r_bramDin;
   assign bram_addra                 = r_bramAddr;
   assign subgraph_bram_ena          = (r_wrRegion == RGN_SUBG);
   assign subgraph_bram_wea          = (r_wrRegion == RGN_SUBG);
   assign h_data_bram_ena            = (r_wrRegion == RGN_H);
   assign h_data_bram_wea            = (r_wrRegion == RGN_H);
   assign h_node_info_bram_ena       = (r_wrRegion == RGN_INFO);
   assign h_node_info_bram_wea       = (r_wrRegion == RGN_INFO);
   assign wgt_bram_ena               = (r_wrRegion == RGN_WGT);
   assign wgt_bram_wea               = (r_wrRegion == RGN_WGT);
   assign h_data_bram_load_done      = r_hDone;
   assign h_node_info_bram_load_done = r_infoDone;
   assign wgt_bram_load_done         = r_wgtDone;
   assign busy                       = (r_state != IDLE);

   gat_feat_reader #(
      .TOP_WIDTH (TOP_WIDTH),
      .DEPTH     (NEW_FEATURE_DEPTH)
   ) u_featReader (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_rdStart),
      .o_done     (w_rdDone),
      .o_featAddr (feat_bram_addrb),
      .i_featDout (feat_bram_dout),
      .o_mData    (m_data),
      .o_mValid   (m_valid),
      .i_mReady   (m_ready),
      .o_mLast    (m_last)
   );

endmodule

// File: tb/tb_gat_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gat_load_ctrl
// Bench for gat_load_ctrl with small regions (2/4/3/5 words, 3 feature words).
// Expected writes come from the region layout arithmetic; the feature BRAM is a
// small array with one cycle read latency.
// Configuration macro: GAT_LOAD_TIMEOUT_EN adds the timeout scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gat_load_ctrl;

   localparam int NWORDS = 14;
   localparam int NFEAT  = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] bram_din;
   logic [4:0]  bram_addra;
   logic        subgraph_bram_ena, subgraph_bram_wea;
   logic        h_data_bram_ena, h_data_bram_wea;
   logic        h_node_info_bram_ena, h_node_info_bram_wea;
   logic        wgt_bram_ena, wgt_bram_wea;
   logic        h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done;
   logic        gat_ready;
   logic [3:0]  feat_bram_addrb;
   logic [31:0] feat_bram_dout;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        busy;
   logic        err;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   typedef struct {
      int          region;
      int          addr;
      logic [31:0] data;
      logic [2:0]  flags;
      int          cyc;
   } wr_t;

   wr_t         wrLog[$];
   wr_t         ev;
   logic [7:0]  strobes;
   logic [31:0] featMem[4];
   logic [88:0] allOuts;

   gat_load_ctrl #(
      .TOP_WIDTH          (32),
      .SUBGRAPH_IDX_DEPTH (2),
      .H_DATA_DEPTH       (4),
      .NODE_INFO_DEPTH    (3),
      .WEIGHT_DEPTH       (5),
      .NEW_FEATURE_DEPTH  (NFEAT)
`ifdef GAT_LOAD_TIMEOUT_EN
      ,.TIMEOUT_CYCLES    (8)
`endif
   ) dut (
      .clk                        (clk),
      .rst                        (rst),
      .start                      (start),
      .s_data                     (s_data),
      .s_valid                    (s_valid),
      .s_ready                    (s_ready),
      .bram_din                   (bram_din),
      .bram_addra                 (bram_addra),
      .subgraph_bram_ena          (subgraph_bram_ena),
      .subgraph_bram_wea          (subgraph_bram_wea),
      .h_data_bram_ena            (h_data_bram_ena),
      .h_data_bram_wea            (h_data_bram_wea),
      .h_node_info_bram_ena       (h_node_info_bram_ena),
      .h_node_info_bram_wea       (h_node_info_bram_wea),
      .wgt_bram_ena               (wgt_bram_ena),
      .wgt_bram_wea               (wgt_bram_wea),
      .h_data_bram_load_done      (h_data_bram_load_done),
      .h_node_info_bram_load_done (h_node_info_bram_load_done),
      .wgt_bram_load_done         (wgt_bram_load_done),
      .gat_ready                  (gat_ready),
      .feat_bram_addrb            (feat_bram_addrb),
      .feat_bram_dout             (feat_bram_dout),
      .m_data                     (m_data),
      .m_valid                    (m_valid),
      .m_ready                    (m_ready),
      .m_last                     (m_last),
      .busy                       (busy),
      .err                        (err)
   );

   // Free-running clock and cycle counter used to time-stamp writes.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Feature BRAM model: one cycle read latency.
   always @(posedge clk) feat_bram_dout <= featMem[feat_bram_addrb[3:2]];

   assign allOuts = {s_ready, bram_din, bram_addra,
                     subgraph_bram_ena, subgraph_bram_wea, h_data_bram_ena, h_data_bram_wea,
                     h_node_info_bram_ena, h_node_info_bram_wea, wgt_bram_ena, wgt_bram_wea,
                     h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done,
                     feat_bram_addrb, m_data, m_valid, m_last, busy, err};

   // Record every cycle with any write strobe; an illegal strobe combination
   // is logged as region -1.
   always @(negedge clk) begin
      if (!rst) begin
         strobes = {subgraph_bram_ena, subgraph_bram_wea, h_data_bram_ena, h_data_bram_wea,
                    h_node_info_bram_ena, h_node_info_bram_wea, wgt_bram_ena, wgt_bram_wea};
         if (strobes != 8'd0) begin
            case (strobes)
               8'b11000000: ev.region = 0;
               8'b00110000: ev.region = 1;
               8'b00001100: ev.region = 2;
               8'b00000011: ev.region = 3;
               default:     ev.region = -1;
            endcase
            ev.addr  = int'(bram_addra);
            ev.data  = bram_din;
            ev.flags = {h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done};
            ev.cyc   = cyc;
            wrLog.push_back(ev);
         end
      end
   end

   // Reference layout: word k of the stream lands in the first region whose
   // cumulative depth exceeds k; a region's done flag is up from its last word on.
   function automatic void expWrite(input int k, output int rgn, output int addr,
                                    output logic [2:0] flags);
      int depth[4];
      int base;
      depth = '{2, 4, 3, 5};
      base  = 0;
      rgn   = -1;
      addr  = 0;
      flags = 3'b000;
      for (int r = 0; r < 4; r++) begin
         if (rgn < 0 && k < base + depth[r]) begin
            rgn  = r;
            addr = (k - base) * 4;
         end
         if (r > 0 && k >= base + depth[r] - 1) flags[3 - r] = 1'b1;
         base += depth[r];
      end
   endfunction

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (allOuts !== '0) $display("[TB] FAIL reset_outputs: got %h, want 0", allOuts);
      else passes++;
   endtask

   // Full load, contiguous or with random s_valid gaps (plus a stray start
   // pulse that must be ignored), checked write by write.
   task automatic test_load(input bit withStalls, input bit countData);
      logic [31:0] words[NWORDS];
      int          accCyc[$];
      int          guard;
      int          gap;
      int          eRgn;
      int          eAddr;
      logic [2:0]  eFlags;
      for (int i = 0; i < NWORDS; i++) words[i] = countData ? 32'(i) : $urandom;
      pulseStart();
      wrLog.delete();
      for (int i = 0; i < NWORDS; i++) begin
         if (withStalls) begin
            gap = $urandom_range(0, 2);
            if (i == 7 && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) begin
               s_valid = 1'b0;
               s_data  = $urandom;
               if (i == 7) start = 1'b1;
               @(posedge clk); #1;
               start = 1'b0;
            end
         end
         s_valid = 1'b1;
         s_data  = words[i];
         guard   = 0;
         while (!s_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard >= 20) begin
            checks++;
            $display("[TB] FAIL load_ready_wait: s_ready stayed %b at word %0d, want 1", s_ready, i);
            break;
         end
         @(posedge clk); #1;
         accCyc.push_back(cyc);
      end
      s_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (wrLog.size() !== NWORDS) $display("[TB] FAIL write_count: got %0d, want %0d", wrLog.size(), NWORDS);
      else passes++;
      for (int k = 0; k < NWORDS && k < wrLog.size() && k < accCyc.size(); k++) begin
         expWrite(k, eRgn, eAddr, eFlags);
         checks++;
         if (wrLog[k].region !== eRgn || wrLog[k].addr !== eAddr || wrLog[k].data !== words[k] ||
             wrLog[k].flags !== eFlags || wrLog[k].cyc !== accCyc[k])
            $display("[TB] FAIL write%0d: got rgn=%0d addr=%0d data=%h flags=%b cyc=%0d, want rgn=%0d addr=%0d data=%h flags=%b cyc=%0d",
                     k, wrLog[k].region, wrLog[k].addr, wrLog[k].data, wrLog[k].flags, wrLog[k].cyc,
                     eRgn, eAddr, words[k], eFlags, accCyc[k]);
         else passes++;
      end
      checks++;
      if ({s_ready, busy, h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done} !== 5'b01111)
         $display("[TB] FAIL wait_gat_status: got %b, want 01111",
                  {s_ready, busy, h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done});
      else passes++;
   endtask

   // Readout of all feature words; word 1 is stalled for 4 cycles in the fixed
   // pattern run, otherwise m_ready is random.
   task automatic test_readout(input bit randomReady, input bit pattern);
      int got;
      int cycles;
      int stallLeft;
      got       = 0;
      cycles    = 0;
      stallLeft = pattern ? 4 : 0;
      for (int i = 0; i < 4; i++) featMem[i] = pattern ? 32'hA0 + 32'(i) : $urandom;
      gat_ready = 1'b1;
      while (got < NFEAT && cycles < 200) begin
         if (m_valid) begin
            checks++;
            if ({m_data, m_last} !== {featMem[got], (got == NFEAT - 1)})
               $display("[TB] FAIL readout_word%0d: got data=%h last=%b, want data=%h last=%b",
                        got, m_data, m_last, featMem[got], (got == NFEAT - 1));
            else passes++;
            if (got == 1 && stallLeft > 0) begin
               m_ready = 1'b0;
               stallLeft--;
            end else begin
               m_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (m_ready) got++;
         end else begin
            checks++;
            if (m_last !== 1'b0) $display("[TB] FAIL readout_last_idle: got %b, want 0", m_last);
            else passes++;
            m_ready = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         cycles++;
      end
      gat_ready = 1'b0;
      m_ready   = 1'b0;
      if (got < NFEAT) begin
         checks++;
         $display("[TB] FAIL readout_timeout: got %0d words, want %0d", got, NFEAT);
      end
      checks++;
      if ({busy, m_valid, s_ready} !== 3'b000)
         $display("[TB] FAIL readout_end_idle: got busy/valid/ready=%b, want 000", {busy, m_valid, s_ready});
      else passes++;
   endtask

   // Reset asserted in LD_H after two of its words must zero everything at
   // once; a new run then restarts writing at subgraph address 0.
   task automatic test_reset_midload();
      logic [31:0] w0;
      pulseStart();
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = 32'd100 + 32'(i);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (allOuts !== '0) $display("[TB] FAIL reset_async: got %h, want 0", allOuts);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (allOuts !== '0) $display("[TB] FAIL reset_held: got %h, want 0", allOuts);
      else passes++;
      rst = 1'b0;
      @(posedge clk); #1;
      wrLog.delete();
      pulseStart();
      w0      = $urandom;
      s_valid = 1'b1;
      s_data  = w0;
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (wrLog.size() !== 1) $display("[TB] FAIL reload_count: got %0d, want 1", wrLog.size());
      else if (wrLog[0].region !== 0 || wrLog[0].addr !== 0 || wrLog[0].data !== w0)
         $display("[TB] FAIL reload_first: got rgn=%0d addr=%0d data=%h, want rgn=0 addr=0 data=%h",
                  wrLog[0].region, wrLog[0].addr, wrLog[0].data, w0);
      else passes++;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

`ifdef GAT_LOAD_TIMEOUT_EN
   // With gat_ready held low, err rises after exactly 8 WAIT_GAT cycles and a
   // start clears it and restarts the load.
   task automatic test_timeout();
      int lastCyc;
      pulseStart();
      for (int i = 0; i < NWORDS; i++) begin
         s_valid = 1'b1;
         s_data  = $urandom;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      lastCyc = cyc;
      while (cyc < lastCyc + 7) begin @(posedge clk); #1; end
      checks++;
      if (err !== 1'b0) $display("[TB] FAIL timeout_early: got err=%b, want 0", err);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if ({err, busy, s_ready} !== 3'b110) $display("[TB] FAIL timeout_err: got err/busy/ready=%b, want 110", {err, busy, s_ready});
      else passes++;
      pulseStart();
      checks++;
      if ({err, s_ready} !== 2'b01) $display("[TB] FAIL timeout_restart: got err/ready=%b, want 01", {err, s_ready});
      else passes++;
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      s_valid   = 1'b0;
      s_data    = '0;
      gat_ready = 1'b0;
      m_ready   = 1'b0;
      for (int i = 0; i < 4; i++) featMem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      test_load(1'b0, 1'b1);
      test_readout(1'b0, 1'b1);
      test_load(1'b1, 1'b0);
      test_readout(1'b1, 1'b0);
      test_reset_midload();
`ifdef GAT_LOAD_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
